// File: rtl/trap_controller_if.sv
// Pipeline/CSR handshake bundle for trap_controller.
//   Exception flags, mret and pipe_drained come from the pipeline.
//   trap_req/trap_valid/trap_pc redirect the pipeline.
//   mcause/mepc/mstatus strobes go to the CSR file.
// modport master : the trap controller (issues trap requests and CSR strobes)
// modport slave  : the pipeline / CSR file side
interface trap_controller_if;
   logic        inst_addr_misaligned;
   logic        invalid_inst;
   logic        load_misaligned;
   logic        store_misaligned;
   logic        mret;
   logic        pipe_drained;
   logic        trap_req;
   logic        trap_valid;
   logic [31:0] trap_pc;
   logic        mcause_we;
   logic [31:0] mcause_wdata;
   logic        mepc_we;
   logic        mstatus_trap;
   logic        mstatus_mret;

   modport master (
      input  inst_addr_misaligned, invalid_inst, load_misaligned, store_misaligned,
      input  mret, pipe_drained,
      output trap_req, trap_valid, trap_pc, mcause_we, mcause_wdata, mepc_we,
      output mstatus_trap, mstatus_mret
   );

   modport slave (
      output inst_addr_misaligned, invalid_inst, load_misaligned, store_misaligned,
      output mret, pipe_drained,
      input  trap_req, trap_valid, trap_pc, mcause_we, mcause_wdata, mepc_we,
      input  mstatus_trap, mstatus_mret
   );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer for the RV32 CSR block.
// Latches interrupts into mip, prioritises exceptions over interrupts, runs the
// request/drain/redirect handshake with the pipeline and handles mret.
// Ports:
//   clk, reset   core clock, asynchronous active-high reset
//   irq_in       raw interrupt lines (line i -> cause code i)
//   mie          per-line enable
//   mstatus_mie  global interrupt enable
//   mtvec        trap base, [1:0]=01 selects vectored mode
//   bus          pipeline/CSR handshake (trap_controller_if.master)
//   mip          pending register
//   busy         FSM not idle
// Optional macro IRQ_SYNC_EN: adds a 2-flop synchronizer on irq_in.
module trap_controller #(
   parameter int          NUM_IRQ       = 16,
   parameter logic [31:0] IRQ_EDGE_MASK = 32'h0000_0000,
   parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_IRQ-1:0]   irq_in,
   input  logic [NUM_IRQ-1:0]   mie,
   input  logic                 mstatus_mie,
   input  logic [31:0]          mtvec,
   trap_controller_if.master    bus,
   output logic [NUM_IRQ-1:0]   mip,
   output logic                 busy
);

   typedef enum logic [1:0] {StIdle, StDrain, StRedirect} state_e;

   state_e               state;
   logic [31:0]          cause_q;
   logic [NUM_IRQ-1:0]   irq_s;
   logic [NUM_IRQ-1:0]   irq_prev;
   logic [NUM_IRQ-1:0]   irq_rise;
   logic [NUM_IRQ-1:0]   mip_d;
   logic [NUM_IRQ-1:0]   pend;
   logic                 int_pend;
   logic [4:0]           irq_idx;
   logic                 exc_any;
   logic [3:0]           exc_code;
   logic [31:0]          base;
   logic [31:0]          next_pc;

`ifdef IRQ_SYNC_EN
   logic [NUM_IRQ-1:0] sync1, sync2;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= irq_in;
         sync2 <= sync1;
      end
   end
   assign irq_s = sync2;
`else
   assign irq_s = irq_in;
`endif

   assign irq_rise = irq_s & ~irq_prev;

   // Edge bits are sticky; they clear only when their own interrupt commits.
   always_comb begin
      mip_d = mip;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (IRQ_EDGE_MASK[i]) begin
            if (irq_rise[i]) begin
               mip_d[i] = 1'b1;
            end else if (state == StRedirect && cause_q[31] && cause_q[4:0] == 5'(i)) begin
               mip_d[i] = 1'b0;
            end
         end else begin
            mip_d[i] = irq_s[i];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mip      <= '0;
         irq_prev <= '0;
      end else begin
         mip      <= mip_d;
         irq_prev <= irq_s;
      end
   end

   assign pend     = mip & mie;
   assign int_pend = (|pend) & mstatus_mie;

   // Lowest index wins: scan downwards so the last hit is the smallest.
   always_comb begin
      irq_idx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (pend[i]) irq_idx = 5'(i);
      end
   end

   assign exc_any = bus.inst_addr_misaligned | bus.invalid_inst |
                    bus.load_misaligned | bus.store_misaligned;

   always_comb begin
      exc_code = 4'd6;
      if (bus.inst_addr_misaligned) exc_code = 4'd0;
      else if (bus.invalid_inst)    exc_code = 4'd2;
      else if (bus.load_misaligned) exc_code = 4'd4;
   end

   assign base    = {mtvec[31:2], 2'b00};
   assign next_pc = (mtvec[1:0] == 2'b01 && cause_q[31]) ?
                    base + {25'b0, cause_q[4:0], 2'b00} : base;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= StIdle;
         cause_q          <= '0;
         busy             <= 1'b0;
         bus.trap_req     <= 1'b0;
         bus.trap_valid   <= 1'b0;
         bus.trap_pc      <= RESET_VECTOR;
         bus.mcause_we    <= 1'b0;
         bus.mcause_wdata <= '0;
         bus.mepc_we      <= 1'b0;
         bus.mstatus_trap <= 1'b0;
         bus.mstatus_mret <= 1'b0;
      end else begin
         bus.trap_valid   <= 1'b0;
         bus.mcause_we    <= 1'b0;
         bus.mepc_we      <= 1'b0;
         bus.mstatus_trap <= 1'b0;
         bus.mstatus_mret <= 1'b0;
         unique case (state)
            StIdle: begin
               if (exc_any) begin
                  cause_q      <= {1'b0, 27'b0, exc_code};
                  state        <= StDrain;
                  bus.trap_req <= 1'b1;
                  busy         <= 1'b1;
               end else if (int_pend) begin
                  cause_q      <= {1'b1, 26'b0, irq_idx};
                  state        <= StDrain;
                  bus.trap_req <= 1'b1;
                  busy         <= 1'b1;
               end else if (bus.mret) begin
                  bus.mstatus_mret <= 1'b1;
               end
            end
            StDrain: begin
               if (bus.pipe_drained) begin
                  state            <= StRedirect;
                  bus.trap_req     <= 1'b0;
                  bus.trap_valid   <= 1'b1;
                  bus.mcause_we    <= 1'b1;
                  bus.mcause_wdata <= cause_q;
                  bus.mepc_we      <= 1'b1;
                  bus.mstatus_trap <= 1'b1;
                  bus.trap_pc      <= next_pc;
               end
            end
            StRedirect: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_trap_controller.sv
// Directed self-checking bench for trap_controller (line 3 edge-triggered).
module tb_trap_controller;
   localparam int          NUM_IRQ = 16;
   localparam logic [31:0] RV      = 32'h0000_0100;

   logic               clk = 1'b0;
   logic               reset;
   logic [NUM_IRQ-1:0] irq_in;
   logic [NUM_IRQ-1:0] mie;
   logic               mstatus_mie;
   logic [31:0]        mtvec;
   logic [NUM_IRQ-1:0] mip;
   logic               busy;
   int                 n_cmp = 0;
   int                 n_err = 0;

   trap_controller_if bus ();

   trap_controller #(
      .NUM_IRQ       (NUM_IRQ),
      .IRQ_EDGE_MASK (32'h0000_0008),
      .RESET_VECTOR  (RV)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .irq_in      (irq_in),
      .mie         (mie),
      .mstatus_mie (mstatus_mie),
      .mtvec       (mtvec),
      .bus         (bus.master),
      .mip         (mip),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset       = 1'b1;
      irq_in      = '0;
      mie         = '0;
      mstatus_mie = 1'b0;
      mtvec       = '0;
      bus.inst_addr_misaligned = 1'b0;
      bus.invalid_inst         = 1'b0;
      bus.load_misaligned      = 1'b0;
      bus.store_misaligned     = 1'b0;
      bus.mret                 = 1'b0;
      bus.pipe_drained         = 1'b0;
      #1;
      chk("rst_trap_pc", bus.trap_pc, RV);
      chk("rst_req", {31'b0, bus.trap_req}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_mip", {16'b0, mip}, 32'd0);
      chk("rst_mcause", bus.mcause_wdata, 32'd0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Vectored level interrupt on line 7
      mtvec = 32'h0000_1001; mie = 16'h0080; mstatus_mie = 1'b1;
      irq_in[7] = 1'b1;
      tick();
      irq_in[7] = 1'b0;
      chk("v_mip", {16'b0, mip}, 32'h0000_0080);
      chk("v_req0", {31'b0, bus.trap_req}, 32'd0);
      tick();
      chk("v_req1", {31'b0, bus.trap_req}, 32'd1);
      chk("v_busy", {31'b0, busy}, 32'd1);
      bus.pipe_drained = 1'b1;
      tick();
      bus.pipe_drained = 1'b0;
      chk("v_valid", {31'b0, bus.trap_valid}, 32'd1);
      chk("v_cause", bus.mcause_wdata, 32'h8000_0007);
      chk("v_pc", bus.trap_pc, 32'h0000_101C);
      chk("v_mepc", {31'b0, bus.mepc_we}, 32'd1);
      chk("v_mstat", {31'b0, bus.mstatus_trap}, 32'd1);
      chk("v_cwe", {31'b0, bus.mcause_we}, 32'd1);
      tick();
      chk("v_valid_off", {31'b0, bus.trap_valid}, 32'd0);
      chk("v_mepc_off", {31'b0, bus.mepc_we}, 32'd0);
      chk("v_busy_off", {31'b0, busy}, 32'd0);

      // Simultaneous exceptions with an interrupt pending
      mtvec = 32'h0000_2001;
      irq_in[7] = 1'b1;
      tick();
      bus.invalid_inst = 1'b1; bus.load_misaligned = 1'b1;
      tick();
      bus.invalid_inst = 1'b0; bus.load_misaligned = 1'b0;
      chk("x_req", {31'b0, bus.trap_req}, 32'd1);
      bus.pipe_drained = 1'b1;
      tick();
      bus.pipe_drained = 1'b0; irq_in[7] = 1'b0; mstatus_mie = 1'b0;
      chk("x_cause", bus.mcause_wdata, 32'h0000_0002);
      chk("x_pc", bus.trap_pc, 32'h0000_2000);
      tick();
      tick();

      // Edge-triggered line 3 with mie masked
      mstatus_mie = 1'b1; mie = '0;
      irq_in[3] = 1'b1;
      tick();
      irq_in[3] = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("e_mip_sticky", {16'b0, mip}, 32'h0000_0008);
      chk("e_idle", {31'b0, busy}, 32'd0);
      mie = 16'h0008;
      tick();
      chk("e_req", {31'b0, bus.trap_req}, 32'd1);
      bus.pipe_drained = 1'b1;
      tick();
      bus.pipe_drained = 1'b0;
      chk("e_cause", bus.mcause_wdata, 32'h8000_0003);
      chk("e_pc", bus.trap_pc, 32'h0000_200C);
      tick();
      chk("e_mip_clr", {16'b0, mip}, 32'd0);
      mie = '0;
      tick();

      // Drain hold with a late store_misaligned
      mtvec = 32'h0000_3000;
      bus.load_misaligned = 1'b1;
      tick();
      bus.load_misaligned = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.store_misaligned = (i == 3);
         chk("d_req", {31'b0, bus.trap_req}, 32'd1);
         chk("d_valid", {31'b0, bus.trap_valid}, 32'd0);
         tick();
      end
      bus.store_misaligned = 1'b0;
      bus.pipe_drained = 1'b1;
      tick();
      bus.pipe_drained = 1'b0;
      chk("d_cause", bus.mcause_wdata, 32'h0000_0004);
      chk("d_pc", bus.trap_pc, 32'h0000_3000);
      tick();

      // mret alone, then mret with invalid_inst
      bus.mret = 1'b1;
      tick();
      bus.mret = 1'b0;
      chk("m_mret", {31'b0, bus.mstatus_mret}, 32'd1);
      chk("m_valid", {31'b0, bus.trap_valid}, 32'd0);
      chk("m_busy", {31'b0, busy}, 32'd0);
      tick();
      chk("m_mret_off", {31'b0, bus.mstatus_mret}, 32'd0);
      bus.mret = 1'b1; bus.invalid_inst = 1'b1;
      tick();
      bus.mret = 1'b0; bus.invalid_inst = 1'b0;
      chk("mx_mret", {31'b0, bus.mstatus_mret}, 32'd0);
      chk("mx_req", {31'b0, bus.trap_req}, 32'd1);
      bus.pipe_drained = 1'b1;
      tick();
      bus.pipe_drained = 1'b0;
      chk("mx_cause", bus.mcause_wdata, 32'h0000_0002);
      chk("mx_valid", {31'b0, bus.trap_valid}, 32'd1);
      tick();

      // Asynchronous reset while draining
      bus.store_misaligned = 1'b1;
      tick();
      bus.store_misaligned = 1'b0;
      chk("r_req", {31'b0, bus.trap_req}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("r_req_off", {31'b0, bus.trap_req}, 32'd0);
      chk("r_busy", {31'b0, busy}, 32'd0);
      chk("r_pc", bus.trap_pc, RV);
      tick();
      reset = 1'b0;
      tick();
      chk("r_idle", {31'b0, bus.trap_req}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Parametrised machine-mode trap sequencer for the RV32 core's CSR block.
- Latches pending interrupts into mip and prioritises exceptions over interrupts.
- Drives a handshake with the pipeline: request, drain, redirect.
- Generates mcause/mepc/mstatus write strobes and the direct or vectored trap PC, and handles mret.

Parameters:
- NUM_IRQ, 16: interrupt lines; 1..32; line i maps to cause code i.
- IRQ_EDGE_MASK, 32'h0000_0000: bit i=1 makes line i edge-triggered (sticky until taken); 0 makes it level.
- RESET_VECTOR, 32'h0000_0000: trap_pc value out of reset.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- irq_in  in  NUM_IRQ  raw interrupt lines
- mie  in  NUM_IRQ  per-line enable (mie CSR)
- mstatus_mie  in  1  global enable
- mtvec  in  32  trap base; [1:0]=01 means vectored, other values mean direct
- inst_addr_misaligned, invalid_inst, load_misaligned, store_misaligned  in  1 each  exception flags from execute, valid for one cycle
- mret  in  1  mret retiring
- pipe_drained  in  1  pipeline has reached an instruction boundary and been flushed
- trap_req  out  1  tell the pipeline to flush and stop fetching
- trap_valid  out  1  one-cycle redirect strobe
- trap_pc  out  32  redirect target
- mcause_we  out  1  write strobe for mcause
- mcause_wdata  out  32  value to write to mcause
- mepc_we  out  1  write strobe for mepc
- mstatus_trap  out  1  CSR file sets MPIE<=MIE and MIE<=0
- mstatus_mret  out  1  CSR file sets MIE<=MPIE and MPIE<=1
- mip  out  NUM_IRQ  pending register, readable through CSR
- busy  out  1  FSM is not IDLE

Behaviour:
- Reset: state=IDLE, mip=0. trap_req, trap_valid, mcause_we, mepc_we, mstatus_trap, mstatus_mret and busy are 0. trap_pc=RESET_VECTOR, mcause_wdata=0.
- mip update, every cycle:
  - Level bit i: mip[i] <= irq_in[i].
  - Edge bit i: set on a 0->1 transition of irq_in[i] (previous value is registered).
  - Edge bit i clears in the same cycle its interrupt is committed in REDIRECT.
  - If set and clear coincide, set wins.
- int_pend = |(mip & mie) & mstatus_mie.
- Interrupt priority: the lowest index among mip & mie wins.
- Exceptions in IDLE are captured immediately. Priority, highest first, with cause codes:
  - inst_addr_misaligned: 0
  - invalid_inst: 2
  - load_misaligned: 4
  - store_misaligned: 6
- FSM states: IDLE, DRAIN, REDIRECT.
  - IDLE:
    - Any exception flag: latch cause {1'b0, 27'b0, code} and go to DRAIN.
    - Else if int_pend: latch cause {1'b1, 26'b0, idx[4:0]} and go to DRAIN.
    - Else if mret: pulse mstatus_mret for 1 cycle and stay in IDLE.
    - An exception and mret in the same cycle: exception wins and mret is ignored.
  - DRAIN: trap_req=1. Wait for pipe_drained=1, then go to REDIRECT. New exceptions and interrupts are ignored; the latched cause is held.
  - REDIRECT, exactly 1 cycle: trap_valid, mcause_we, mepc_we and mstatus_trap are 1, and mcause_wdata holds the latched cause. Next state is IDLE.
- Latency:
  - Trap request: trap_req is asserted the cycle after the event.
  - Redirect: trap_valid is asserted the cycle after pipe_drained is seen.
  - Minimum: 2 cycles from event to redirect.
- Interrupt withdrawal: if the interrupt drops during DRAIN, the trap is still taken with the latched cause. No cancellation.
- trap_pc is registered and loaded when entering REDIRECT:
  - Vectored mode and interrupt: {mtvec[31:2], 2'b00} + (cause_code << 2), 32-bit wrap-around.
  - Otherwise: {mtvec[31:2], 2'b00}.
- Back-to-back traps: the earliest is IDLE 1 cycle after REDIRECT, so at least one idle cycle separates traps. mstatus_trap clears MIE, so pending interrupts are masked until software or mret restores it.
- Reset mid-operation: asynchronous return to the reset values; any latched cause is discarded.

Optional Feature:
- IRQ_SYNC_EN:
  - Defined: irq_in passes through a 2-flop synchronizer (reset to 0) before mip and edge logic, adding 2 cycles of interrupt latency.
  - Undefined: irq_in is used directly and must be synchronous to clk.

Test Plan:
- Vectored interrupt:
  - Setup: mtvec=32'h0000_1001, mie[7]=1, mstatus_mie=1; pulse level irq_in[7]; pipe_drained=1 two cycles later.
  - Expect: trap_req next cycle, then REDIRECT with mcause_wdata=32'h8000_0007 and trap_pc=32'h0000_101C; mepc_we and mstatus_trap pulse once.
- Simultaneous exceptions:
  - Stimulus: invalid_inst and load_misaligned in the same cycle, with an interrupt also pending; mtvec=32'h0000_2001.
  - Expect: mcause_wdata=32'h0000_0002 and trap_pc=32'h0000_2000 (exceptions are never vectored).
- Edge-triggered line, with IRQ_EDGE_MASK[3]=1:
  - A 1-cycle pulse on irq_in[3] with mie[3]=0 keeps mip[3]=1 indefinitely.
  - Setting mie[3]=1 then causes a trap with cause 32'h8000_0003, and mip[3]=0 after REDIRECT.
- Drain hold:
  - Stimulus: hold pipe_drained=0 for 10 cycles during a trap.
  - Expect: trap_req=1 throughout, trap_valid=0, and a new store_misaligned does not change the latched cause.
- mret:
  - mret in IDLE gives a 1-cycle mstatus_mret with no trap_valid.
  - mret together with invalid_inst gives a trap with cause 2 and no mstatus_mret.
- Async reset in DRAIN:
  - Expect: trap_req drops without waiting for clk, busy=0, and trap_pc=RESET_VECTOR.
